// File: rtl/vga_pkg.sv
// Shared VGA attribute-controller types: palette entry/index widths and the
// packed storage type used by the 16-entry attribute palette.
package vga_pkg;

  localparam int PAL_DATA_W = 6;
  localparam int PAL_ADDR_W = 4;
  localparam int PAL_DEPTH  = 2 ** PAL_ADDR_W;

  typedef logic [PAL_DATA_W-1:0] pal_entry_t;
  typedef logic [PAL_ADDR_W-1:0] pal_idx_t;
  typedef logic [PAL_DEPTH-1:0][PAL_DATA_W-1:0] pal_array_t;

endpackage

// File: rtl/pal_read_mux16.sv
// 16:1 palette read mux; shared by the host read-back and pixel read paths.
module pal_read_mux16
  import vga_pkg::*;
(
  input  pal_array_t i_mem,
  input  pal_idx_t   i_idx,
  output pal_entry_t o_data
);

  assign o_data = i_mem[i_idx];

endmodule

// File: rtl/dual_port_16x6_ram.sv
// VGA attribute palette (AR00-AR0F): host write / combinational read-back on
// port 1, registered pixel read on port 2. Build option DPRB_WRITE_FWD_EN
// makes a same-address write visible on dout2 in the same enabled edge.
module dual_port_16x6_ram
  import vga_pkg::*;
#(
  parameter int DATA_W = PAL_DATA_W,
  parameter int ADDR_W = PAL_ADDR_W
) (
  input  logic              clk,
  input  logic              h_reset_n,
  input  logic              h_hclk,
  input  logic              clk_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout1,
  output logic [DATA_W-1:0] dout2
);

  localparam int DEPTH = 2 ** ADDR_W;

  pal_array_t  r_mem;
  pal_entry_t  r_dout2;
  pal_entry_t  w_rd1;
  pal_entry_t  w_rd2;
  pal_entry_t  w_dout2_nxt;
  logic        w_unused_hclk;

  // Host strobes are already synchronous to clk; the host clock is kept only
  // for pin compatibility.
  assign w_unused_hclk = h_hclk;

  always_ff @(posedge clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[addr1] <= din;
    end
  end

  pal_read_mux16 u_rd1 (
    .i_mem  (r_mem),
    .i_idx  (addr1),
    .o_data (w_rd1)
  );

  pal_read_mux16 u_rd2 (
    .i_mem  (r_mem),
    .i_idx  (addr2),
    .o_data (w_rd2)
  );

`ifdef DPRB_WRITE_FWD_EN
  assign w_dout2_nxt = (we && (addr1 == addr2)) ? din : w_rd2;
`else
  // Array read sees pre-write contents, giving read-before-write on collision.
  assign w_dout2_nxt = w_rd2;
`endif

  always_ff @(posedge clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      r_dout2 <= '0;
    end else if (clk_en) begin
      r_dout2 <= w_dout2_nxt;
    end
  end

  assign dout1 = w_rd1;
  assign dout2 = r_dout2;

endmodule

// File: tb/tb_dual_port_16x6_ram.sv
// Self-checking bench for dual_port_16x6_ram: array-level reference model,
// per-cycle compare process, directed literal checks and random traffic.
module tb_dual_port_16x6_ram;

`ifdef DPRB_WRITE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       h_reset_n;
  logic       h_hclk = 1'b0;
  logic       clk_en;
  logic       we;
  logic [3:0] addr1;
  logic [3:0] addr2;
  logic [5:0] din;
  logic [5:0] dout1;
  logic [5:0] dout2;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  logic [5:0] mem_m [16];
  logic [5:0] d2_m;

  always #5 clk = ~clk;
  always #7 h_hclk = ~h_hclk;

  dual_port_16x6_ram dut (
    .clk       (clk),
    .h_reset_n (h_reset_n),
    .h_hclk    (h_hclk),
    .clk_en    (clk_en),
    .we        (we),
    .addr1     (addr1),
    .addr2     (addr2),
    .din       (din),
    .dout1     (dout1),
    .dout2     (dout2)
  );

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: palette contents plus the value latched for the pixel port.
  always @(posedge clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      for (int i = 0; i < 16; i++) mem_m[i] <= 6'h00;
      d2_m <= 6'h00;
    end else begin
      if (clk_en) d2_m <= (FWD && we && addr1 == addr2) ? din : mem_m[addr2];
      if (we) mem_m[addr1] <= din;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dout1_model", dout1, mem_m[addr1]);
      chk("dout2_model", dout2, d2_m);
    end
  end

  task automatic cyc(input logic w, input logic [3:0] a1, input logic [3:0] a2,
                     input logic [5:0] d, input logic en);
    we = w; addr1 = a1; addr2 = a2; din = d; clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 6'($urandom),
          1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    logic [5:0] v;
    h_reset_n = 1'b0;
    we = 1'b0; clk_en = 1'b0; addr1 = '0; addr2 = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout1", dout1, 6'h00);
    chk("reset_dout2", dout2, 6'h00);
    h_reset_n = 1'b1;
    chk_on = 1'b1;

    // Host write / read-back
    cyc(1'b1, 4'd5, 4'd0, 6'h3F, 1'b0);
    cyc(1'b1, 4'd10, 4'd0, 6'h2A, 1'b0);
    cyc(1'b0, 4'd5, 4'd0, 6'h00, 1'b0);
    chk("host_rd5", dout1, 6'h3F);
    addr1 = 4'd10; #1;
    chk("host_rd10", dout1, 6'h2A);
    addr1 = 4'd7; #1;
    chk("host_rd7", dout1, 6'h00);

    // Pixel port enable behaviour
    cyc(1'b0, 4'd0, 4'd10, 6'h00, 1'b1);
    chk("pix_en_10", dout2, 6'h2A);
    cyc(1'b0, 4'd0, 4'd5, 6'h00, 1'b0);
    chk("pix_hold", dout2, 6'h2A);
    cyc(1'b0, 4'd0, 4'd5, 6'h00, 1'b1);
    chk("pix_en_5", dout2, 6'h3F);

    // Same-address collision
    cyc(1'b1, 4'd3, 4'd0, 6'h11, 1'b0);
    cyc(1'b1, 4'd3, 4'd3, 6'h22, 1'b1);
    chk("collide", dout2, FWD ? 6'h22 : 6'h11);
    cyc(1'b0, 4'd0, 4'd3, 6'h00, 1'b1);
    chk("collide_next", dout2, 6'h22);

    // Independence: hammer entry 0 while sweeping the pixel port
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 4'd0, 6'(i + 32), 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 4'd0, 4'(i), 6'($urandom), 1'b1);
      if (i != 0) chk("indep_sweep", dout2, 6'(i + 32));
    end

    // Walk: inverted index pattern, read back on both ports
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 4'd0, ~6'(i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 4'(i), 4'(i), 6'h00, 1'b1);
      v = ~6'(i);
      chk("walk_dout1", dout1, v);
      chk("walk_dout2", dout2, v);
    end

    rnd_cycles(1500);

    // Mid-run async reset
    cyc(1'b1, 4'd9, 4'd9, 6'h15, 1'b1);
    h_reset_n = 1'b0;
    #1;
    chk("async_rst_dout2", dout2, 6'h00);
    for (int i = 0; i < 16; i++) begin
      addr1 = 4'(i);
      #1;
      chk("rst_dout1", dout1, 6'h00);
    end
    @(posedge clk);
    #2;
    h_reset_n = 1'b1;

    rnd_cycles(1500);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
